// File: rtl/seq_nonrestoring_divider.sv
// Sequential non-restoring divider: one quotient bit per cycle on operand magnitudes,
// followed by a one-cycle sign/remainder fix-up. Signed and unsigned operands.
module seq_nonrestoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] HI
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        CORRECT,
        DONE
    } state_t;

    state_t                  state;
    logic [CW-1:0]           iter_cnt;

    logic [WIDTH-1:0]        quo;
    logic [WIDTH-1:0]        dvsr_mag;
    logic [WIDTH-1:0]        dvnd_raw;
    logic signed [WIDTH:0]   rem;
    logic                    q_neg;
    logic                    r_neg;
    logic                    dz;

    logic signed [WIDTH:0]   dvsr_ext;
    logic signed [WIDTH:0]   rem_sh;
    logic signed [WIDTH:0]   rem_step;
    logic [WIDTH-1:0]        rem_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    // Two's-complement negate when the retained sign says so; the most-negative
    // quotient magnitude maps back onto itself, which gives the required wrap.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic neg);
        return neg ? -mag : mag;
    endfunction

    assign dvsr_ext = {1'b0, dvsr_mag};

    always_comb begin
        rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
        if (!rem[WIDTH])
            rem_step = rem_sh - dvsr_ext;
        else
            rem_step = rem_sh + dvsr_ext;
        rem_fix = rem[WIDTH] ? (rem[WIDTH-1:0] + dvsr_mag) : rem[WIDTH-1:0];
    end

    // Datapath: operand capture and the iterative partial remainder / quotient shift.
    always_ff @(posedge clock) begin
        case (state)
            IDLE: begin
                if (start) begin
                    dvnd_raw <= dividend;
                    dvsr_mag <= magnitude(divisor, signed_mode);
                    quo      <= magnitude(dividend, signed_mode);
                    rem      <= '0;
                    q_neg    <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg    <= signed_mode & dividend[WIDTH-1];
                    dz       <= (divisor == '0);
                end
            end
            ITER: begin
                rem <= rem_step;
                quo <= {quo[WIDTH-2:0], ~rem_step[WIDTH]};
            end
            default: ;
        endcase
    end

    // Control FSM and result registers.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            iter_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            LO          <= '0;
            HI          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    iter_cnt <= '0;
                    if (start) begin
                        if (divisor == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ITER;
                            busy  <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    if (iter_cnt == CW'(WIDTH - 1)) begin
                        iter_cnt <= '0;
                        state    <= CORRECT;
                    end else begin
                        iter_cnt <= iter_cnt + CW'(1);
                    end
                end
                CORRECT: begin
                    LO          <= apply_sign(quo, q_neg);
                    HI          <= apply_sign(rem_fix, r_neg);
                    div_by_zero <= 1'b0;
                    busy        <= 1'b0;
                    state       <= DONE;
                end
                DONE: begin
                    done <= 1'b1;
                    if (dz) begin
                        LO          <= '1;
                        HI          <= dvnd_raw;
                        div_by_zero <= 1'b1;
                    end
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Bench for seq_nonrestoring_divider: directed vector table, handshake/abort sequences,
// and parallel randomized lanes compared against plain / and % arithmetic.
module tb_seq_nonrestoring_divider;

    localparam int W        = 32;
    localparam int LANES    = 8;
    localparam int PER_LANE = 1250;

    logic         clock;
    logic         clear;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] LO;
    logic [W-1:0] HI;

    int checks;
    int errors;
    int lanes_done;
    bit rand_go;

    seq_nonrestoring_divider #(.WIDTH(W)) u_dut (
        .clock(clock), .clear(clear), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .LO(LO), .HI(HI)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         sm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         z;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor yields all-ones / dividend.
    function automatic void ref_div(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        longint sa, sb;
        z = 1'b0;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (sm) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic wait_done(inout int lat, output bit to);
        to = 1'b1;
        while (to && lat < W + 8) begin
            @(posedge clock);
            #1;
            lat++;
            if (done) to = 1'b0;
        end
    endtask

    task automatic run_div(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output bit to);
        @(negedge clock);
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        start       = 1'b1;
        @(posedge clock);
        #1;
        start       = 1'b0;
        dividend    = $urandom;
        divisor     = $urandom;
        signed_mode = 1'($urandom);
        lat = 0;
        wait_done(lat, to);
    endtask

    for (genvar g = 0; g < LANES; g++) begin : lane
        logic         l_start, l_sm, l_busy, l_done, l_dbz;
        logic [W-1:0] l_a, l_b, l_lo, l_hi;

        seq_nonrestoring_divider #(.WIDTH(W)) u_lane (
            .clock(clock), .clear(clear), .start(l_start), .signed_mode(l_sm),
            .dividend(l_a), .divisor(l_b), .busy(l_busy), .done(l_done),
            .div_by_zero(l_dbz), .LO(l_lo), .HI(l_hi)
        );

        initial begin
            logic [W-1:0] a, b, eq, er;
            logic         sm, ez;
            logic [7:0]   elat;
            int           lat;
            l_start = 1'b0; l_sm = 1'b0; l_a = '0; l_b = '0;
            wait (rand_go);
            for (int i = 0; i < PER_LANE; i++) begin
                sm = 1'($urandom);
                a  = $urandom;
                b  = $urandom;
                case ($urandom_range(7, 0))
                    4: b = W'($urandom_range(15, 0));
                    5: b = '0;
                    6: begin a = 32'h8000_0000; if ($urandom_range(1, 0) == 1) b = '1; end
                    7: a = W'($urandom_range(255, 0));
                    default: ;
                endcase
                ref_div(sm, a, b, eq, er, ez);
                elat = (b == '0) ? 8'd1 : 8'(W + 2);
                @(negedge clock);
                l_sm = sm; l_a = a; l_b = b; l_start = 1'b1;
                @(posedge clock);
                #1;
                l_start = 1'b0; l_a = $urandom; l_b = $urandom; l_sm = 1'($urandom);
                lat = 0;
                while (lat < W + 8) begin
                    @(posedge clock);
                    #1;
                    lat++;
                    if (l_done) break;
                end
                check($sformatf("lane%0d rand %0d sm=%0d %h/%h {lo,hi,dbz,busy,lat}", g, i, sm, a, b),
                      {l_lo, l_hi, l_dbz, l_busy, lat[7:0]}, {eq, er, ez, 1'b0, elat});
            end
            lanes_done++;
        end
    end

    initial begin
        int lat, cyc, t1, t2, ndone;
        bit to;

        checks = 0; errors = 0; lanes_done = 0; rand_go = 1'b0;
        clear = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;

        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};
        vecs[1]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 34};
        vecs[2]  = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0000, 1'b0, 34};
        vecs[3]  = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0002, 32'h7FFF_FFFE, 32'h0000_0000, 1'b0, 34};
        vecs[4]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34};
        vecs[5]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 34};
        vecs[6]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 34};
        vecs[7]  = '{1'b1, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1};
        vecs[8]  = '{1'b0, 32'h0000_0040, 32'h0000_0007, 32'h0000_0009, 32'h0000_0001, 1'b0, 34};
        vecs[9]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 34};
        vecs[10] = '{1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002, 1'b0, 34};
        vecs[11] = '{1'b0, 32'h0000_0005, 32'h0000_0009, 32'h0000_0000, 32'h0000_0005, 1'b0, 34};

        repeat (2) @(posedge clock);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset dbz", div_by_zero, 1'b0);
        check("reset LO/HI", {LO, HI}, 64'h0);
        @(negedge clock);
        clear = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].sm, vecs[i].a, vecs[i].b, lat, to);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d LO", i), LO, vecs[i].lo);
            check($sformatf("vec%0d HI", i), HI, vecs[i].hi);
            check($sformatf("vec%0d dbz", i), div_by_zero, vecs[i].z);
            check($sformatf("vec%0d busy at done", i), busy, 1'b0);
        end

        repeat (5) @(posedge clock);
        #1;
        check("hold after done {done,LO,HI}", {done, LO, HI}, {1'b0, 32'h0, 32'h5});

        // Second start while busy must be ignored.
        @(negedge clock);
        signed_mode = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat = 0;
        repeat (5) begin @(posedge clock); #1; lat++; end
        check("busy mid-division", busy, 1'b1);
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clock);
        #1;
        lat++;
        start = 1'b0;
        wait_done(lat, to);
        check("ignored start latency", lat, W + 2);
        check("ignored start result", {LO, HI}, {32'd14, 32'd2});
        ndone = 0;
        repeat (W + 6) begin @(posedge clock); #1; if (done) ndone++; end
        check("ignored start no extra done", ndone, 0);

        // Abort with clear after ten iterations.
        @(negedge clock);
        signed_mode = 1'b0; dividend = 32'h1234_5678; divisor = 32'd3; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        clear = 1'b1;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort done/dbz", {done, div_by_zero}, 2'b00);
        check("abort LO/HI", {LO, HI}, 64'h0);
        @(negedge clock);
        clear = 1'b0;
        ndone = 0;
        repeat (45) begin @(posedge clock); #1; if (done) ndone++; end
        check("abort no done", ndone, 0);
        run_div(1'b0, 32'd64, 32'd7, lat, to);
        check("after abort latency", lat, W + 2);
        check("after abort result", {LO, HI}, {32'd9, 32'd1});

        // Start held high: back-to-back divisions.
        @(negedge clock);
        signed_mode = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        cyc = 0; t1 = 0; t2 = 0;
        while (t2 == 0 && cyc < 120) begin
            @(posedge clock);
            #1;
            cyc++;
            if (done) begin
                if (t1 == 0) begin
                    t1 = cyc;
                    check("held start result", {LO, HI}, {32'd333, 32'd1});
                end else begin
                    t2 = cyc;
                end
            end
        end
        @(negedge clock);
        start = 1'b0;
        check("held start period", t2 - t1, W + 3);
        repeat (W + 6) @(posedge clock);

        rand_go = 1'b1;
        for (int t = 0; t < 60000 && lanes_done < LANES; t++) @(posedge clock);
        check("random lanes completed", lanes_done, LANES);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_nonrestoring_divider.md
SEQ_NONRESTORING_DIVIDER -- requirements
Module: seq_nonrestoring_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (WIDTH >= 4).
REQ-002 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clear, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: request a division; sampled on a rising edge while not busy.
REQ-005 SHALL have port signed_mode, input, 1: 1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-006 SHALL have port dividend, input, WIDTH: numerator; captured with start.
REQ-007 SHALL have port divisor, input, WIDTH: denominator; captured with start.
REQ-008 SHALL have port busy, output, 1: high while a division is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse marking LO/HI/div_by_zero valid.
REQ-010 SHALL have port div_by_zero, output, 1: the last result had divisor == 0.
REQ-011 SHALL have port LO, output, WIDTH: quotient.
REQ-012 SHALL have port HI, output, WIDTH: remainder.

Function
REQ-013 SHALL implement FSM states IDLE, ITER, CORRECT, DONE; the encoding is free.
REQ-014 In IDLE, start=1 at an edge SHALL capture the operands and signed_mode; next state ITER, or DONE if divisor == 0.
REQ-015 In signed mode, the captured operands SHALL be converted to magnitudes; the quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign) SHALL be retained.
REQ-016 ITER SHALL perform exactly one non-restoring step per cycle for WIDTH cycles, as follows.
  - Partial remainder is WIDTH+1 bits, signed.
  - Shift left {remainder, quotient} by one bit.
  - Subtract the divisor if the remainder is >= 0, else add it.
  - The new quotient LSB is 1 if the result is >= 0, else 0.
  - A WIDTH-modulo iteration counter SHALL select the transition to CORRECT after the last step.
REQ-017 CORRECT (1 cycle) SHALL finish the result.
  - If the remainder is < 0, add the divisor back.
  - Apply the retained signs: quotient truncated toward zero; a nonzero remainder takes the dividend's sign.
  - Register LO and HI; next state DONE.
REQ-018 DONE (1 cycle) SHALL assert done=1; next state IDLE.
REQ-019 Latency: done SHALL be high exactly WIDTH+2 edges after the edge that captured start, with LO/HI valid in the same cycle; the divide-by-zero case completes in 1 edge instead.
REQ-020 busy SHALL be high in ITER and CORRECT and low in IDLE and DONE.
REQ-021 start SHALL be ignored while busy=1 or in DONE.
REQ-022 start held continuously SHALL begin a new division every WIDTH+3 cycles.
REQ-023 Divisor == 0 SHALL produce LO = all ones, HI = dividend unmodified, and div_by_zero=1, in either mode.
REQ-024 div_by_zero SHALL be 0 for every nonzero divisor.
REQ-025 For signed most-negative / -1, the result SHALL wrap: LO = most-negative value, HI = 0, div_by_zero=0.
REQ-026 LO, HI and div_by_zero SHALL hold their values from the DONE cycle until the next CORRECT/DONE update or clear.
REQ-027 Operand inputs changing after the start edge SHALL NOT affect the result in progress.

Reset
REQ-028 clear=1 SHALL immediately force state IDLE and zero the iteration counter.
REQ-029 clear=1 SHALL immediately force busy=0, done=0, div_by_zero=0, LO=0, HI=0, regardless of the clock.
REQ-030 clear asserted mid-division SHALL abort it with no done pulse; the first start after clear deasserts SHALL divide normally.

Verification (WIDTH=32)
REQ-031 Divide by zero: dividend=0, divisor=0, start -> done 1 edge later, div_by_zero=1, LO=FFFFFFFF, HI=00000000.
REQ-032 Sign and mode handling SHALL be covered by these cases, each with done exactly 34 edges after start.
  - signed FFFFFFFF / FFFFFFFF -> LO=00000001, HI=00000000.
  - signed FFFFFFFC / 00000002 -> LO=FFFFFFFE, HI=00000000.
  - unsigned FFFFFFFC / 00000002 -> LO=7FFFFFFE, HI=00000000.
REQ-033 Signed remainder sign: FFFFFFF9 (-7) / 00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; and 00000007 / FFFFFFFE -> LO=FFFFFFFD, HI=00000001.
REQ-034 Overflow: signed 80000000 / FFFFFFFF -> LO=80000000, HI=00000000, div_by_zero=0.
REQ-035 Handshake and abort SHALL be covered by these cases.
  - A second start pulse during busy with different operands -> ignored; the first result is delivered unchanged.
  - clear pulse at iteration 10 -> all outputs 0 immediately; no done; a new start of 64/7 unsigned -> LO=00000009, HI=00000001.
REQ-036 A randomised bench SHALL check at least 10000 operand pairs in both modes against reference / and % semantics of REQ-017, REQ-023 and REQ-025.
